// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, FSM states, mux selects.
// Also holds the Moore output table, so decode stays in one place.
package ctrl_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, JAL, BEQ, LUI, TRAP
  } state_t;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] RES_IMMEXT    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       illegal;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // In FETCH, ir_write means "fetch requested"; the top gates it (and pc_update) with ready.
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.ir_write = 1'b1; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALURESULT; end
      DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
      MEMADR:   begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; end
      MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      MEMWB:    begin c.result_src = RES_DATA; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECR:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALU_FUNCT; end
      EXECI:    begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
      ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.pc_update = 1'b1; end
      BEQ:      begin c.alu_src_a = SRCA_RD1; c.alu_src_b = SRCB_RD2; c.alu_op = ALU_SUB; c.branch = 1'b1; end
      LUI:      begin c.result_src = RES_IMMEXT; c.reg_write = 1'b1; end
      TRAP:     c.illegal = 1'b1;
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between instruction register/ALU flags and the datapath muxes and enables.
// master = control unit, slave = datapath side.
interface multicycle_ctrl_fsm_if #(parameter int IMM_SRC_W = 3);
  logic [6:0]           op;
  logic                 zero;
  logic                 mem_ready;
  logic                 pc_write;
  logic                 adr_src;
  logic                 mem_write;
  logic                 ir_write;
  logic                 reg_write;
  logic [1:0]           result_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [1:0]           alu_op;
  logic [IMM_SRC_W-1:0] imm_src;
  logic                 illegal;

  modport master (
    input  op, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
  );

  modport slave (
    output op, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_instr_decoder.sv
// Opcode to immediate-format select; purely combinational, zero latency.
module instr_decoder
  import ctrl_pkg::*;
#(
  parameter int IMM_SRC_W = 3
) (
  input  logic [6:0]           op,
  output logic [IMM_SRC_W-1:0] imm_src
);

  logic [2:0] fmt;

  always_comb begin
    fmt = IMM_I;
    case (op)
      OP_LW, OP_I:      fmt = IMM_I;
      OP_SW:            fmt = IMM_S;
      OP_BEQ:           fmt = IMM_B;
      OP_JAL:           fmt = IMM_J;
      OP_LUI, OP_AUIPC: fmt = IMM_U;
      default:          fmt = IMM_I;
    endcase
  end

  assign imm_src = IMM_SRC_W'(fmt);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: Moore outputs registered alongside state, imm_src/pc_write combinational.
// FETCH/MEMREAD/MEMWRITE stall on mem_ready when MEM_WAIT=1; reset forces every output low.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter bit EN_UTYPE  = 1'b1,
  parameter bit MEM_WAIT  = 1'b0,
  parameter int IMM_SRC_W = 3
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_ctrl_fsm_if.master bus
);

  state_t               state;
  ctrl_t                ctrl_q;
  logic                 ready;
  logic                 fetch_go;
  logic [IMM_SRC_W-1:0] imm_dec;

  assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

  function automatic state_t next_state(input state_t s, input logic [6:0] op, input logic rdy);
    state_t n;
    n = s;
    case (s)
      FETCH:    n = rdy ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: n = MEMADR;
          OP_R:         n = EXECR;
          OP_I:         n = EXECI;
          OP_JAL:       n = JAL;
          OP_BEQ:       n = BEQ;
          OP_LUI:       n = EN_UTYPE ? LUI : TRAP;
          OP_AUIPC:     n = EN_UTYPE ? ALUWB : TRAP;  // OldPC+imm already sits in ALUOut
          default:      n = TRAP;
        endcase
      end
      MEMADR:   n = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  n = rdy ? MEMWB : MEMREAD;
      MEMWB:    n = FETCH;
      MEMWRITE: n = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: n = ALUWB;
      ALUWB, BEQ, LUI:   n = FETCH;
      TRAP:     n = TRAP;
      default:  n = FETCH;
    endcase
    return n;
  endfunction

  // Outputs for the next state are computed with it so they leave a flop, not the state decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      ctrl_q <= state_ctrl(FETCH);
    end else begin
      state  <= next_state(state, bus.op, ready);
      ctrl_q <= state_ctrl(next_state(state, bus.op, ready));
    end
  end

  instr_decoder #(.IMM_SRC_W(IMM_SRC_W)) u_instr_decoder (
    .op      (bus.op),
    .imm_src (imm_dec)
  );

  assign fetch_go = ctrl_q.ir_write & ready;

  assign bus.pc_write   = ~reset & (ctrl_q.pc_update | fetch_go | (ctrl_q.branch & bus.zero));
  assign bus.adr_src    = ~reset & ctrl_q.adr_src;
  assign bus.mem_write  = ~reset & ctrl_q.mem_write;
  assign bus.ir_write   = ~reset & fetch_go;
  assign bus.reg_write  = ~reset & ctrl_q.reg_write;
  assign bus.result_src = reset ? 2'b00 : ctrl_q.result_src;
  assign bus.alu_src_a  = reset ? 2'b00 : ctrl_q.alu_src_a;
  assign bus.alu_src_b  = reset ? 2'b00 : ctrl_q.alu_src_b;
  assign bus.alu_op     = reset ? 2'b00 : ctrl_q.alu_op;
  assign bus.imm_src    = reset ? '0 : imm_dec;
  assign bus.illegal    = ~reset & ctrl_q.illegal;

endmodule
